// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing the register file's single
// write port between N_REQ write-back requesters. The grant (req_ready) is
// combinational; the winning request is registered onto the decode-stage
// write interface one cycle later.
module wb_port_arbiter #(
    parameter int N_REQ      = 3,
    parameter int N_SIZE     = 16,
    parameter int N_REGISTER = 8,
    parameter int N_NUMBERS  = $clog2(N_REGISTER),
    localparam int PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*N_NUMBERS-1:0] req_Rd_NUM,
    input  logic [N_REQ*N_SIZE-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       write_flag,
    output logic [N_NUMBERS-1:0]       Rd_write_NUM,
    output logic [N_SIZE-1:0]          writeData,
    output logic [PW-1:0]              grant_id
);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win;
    logic          found;
    logic          grant_en;

    // Scan requesters starting at rr_ptr, wrapping explicitly at N_REQ so a
    // non-power-of-2 requester count never lands on a nonexistent index.
    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            if (idx == PW'(N_REQ - 1)) idx = '0;
            else                       idx = idx + 1'b1;
        end
    end

    // Reset gates the grant so nothing is accepted while the port is cleared.
    assign grant_en = found && !stall && !reset;

    // One-hot grant to the winner only; all-zero when nothing is granted.
    for (genvar i = 0; i < N_REQ; i++) begin : g_ready
        assign req_ready[i] = grant_en && (win == PW'(i));
    end

    // Register the winning request; pointer moves one past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_flag   <= 1'b0;
            Rd_write_NUM <= '0;
            writeData    <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
        end else if (grant_en) begin
            write_flag   <= 1'b1;
            Rd_write_NUM <= req_Rd_NUM[win*N_NUMBERS +: N_NUMBERS];
            writeData    <= req_data[win*N_SIZE +: N_SIZE];
            grant_id     <= win;
            rr_ptr       <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end else begin
            write_flag   <= 1'b0;
        end
    end

endmodule
